// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter: load -> port x, pipeline -> port y,
// queued divide/sqrt results fill whichever port is idle.
module fp_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_we,
  input  logic [4:0]    ld_wn,
  input  logic [31:0]   ld_d,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_wn,
  input  logic [31:0]   pipe_d,
  input  logic          dv_valid,
  output logic          dv_ready,
  input  logic [4:0]    dv_wn,
  input  logic [31:0]   dv_d,
  output logic          wex,
  output logic [4:0]    wnx,
  output logic [31:0]   dx,
  output logic          wey,
  output logic [4:0]    wny,
  output logic [31:0]   dy,
  output logic [31:0]   pend_mask,
  output logic [AW:0]   q_count
);

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       wn_q [DEPTH];
  logic [31:0]      d_q  [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic             wex_q, wex_d, wey_q, wey_d;
  logic [4:0]       wnx_q, wnx_d, wny_q, wny_d;
  logic [31:0]      dx_q, dx_d, dy_q, dy_d;

  logic             head_occ, head_live, pop, enq, enq_live;

  // Count never exceeds DEPTH (a power of two), so its MSB alone flags full.
  assign dv_ready = ~cnt_q[AW];
  assign q_count  = cnt_q;

  assign wex = wex_q;
  assign wnx = wnx_q;
  assign dx  = dx_q;
  assign wey = wey_q;
  assign wny = wny_q;
  assign dy  = dy_q;

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend_mask[wn_q[i]] = 1'b1;
    end
  end

  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((ld_we && ld_wn == wn_q[i]) || (pipe_we && pipe_wn == wn_q[i]))
        live_d[i] = 1'b0;
    end

    wex_d = ld_we;
    wnx_d = ld_wn;
    dx_d  = ld_d;
    wey_d = pipe_we;
    wny_d = pipe_wn;
    dy_d  = pipe_d;

    // Head liveness is judged after this cycle's kills, so a stale queued
    // value can never land on a port beside the younger result it lost to.
    head_occ  = (cnt_q != '0);
    head_live = head_occ && live_d[rd_q];
    pop       = 1'b0;
    if (head_occ) begin
      if (!head_live) begin
        pop = 1'b1;
      end else if (!ld_we) begin
        wex_d = 1'b1;
        wnx_d = wn_q[rd_q];
        dx_d  = d_q[rd_q];
        pop   = 1'b1;
      end else if (!pipe_we) begin
        wey_d = 1'b1;
        wny_d = wn_q[rd_q];
        dy_d  = d_q[rd_q];
        pop   = 1'b1;
      end
    end
    if (pop) live_d[rd_q] = 1'b0;

    enq      = dv_valid && dv_ready;
    enq_live = !(ld_we && ld_wn == dv_wn) && !(pipe_we && pipe_wn == dv_wn);
    if (enq) live_d[wr_q] = enq_live;

    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(enq);
    cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      wex_q  <= 1'b0;
      wnx_q  <= '0;
      dx_q   <= '0;
      wey_q  <= 1'b0;
      wny_q  <= '0;
      dy_q   <= '0;
    end else begin
      live_q <= live_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      wex_q  <= wex_d;
      wnx_q  <= wnx_d;
      dx_q   <= dx_d;
      wey_q  <= wey_d;
      wny_q  <= wny_d;
      dy_q   <= dy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wn_q[wr_q] <= dv_wn;
      d_q[wr_q]  <= dv_d;
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed + randomized bench for fp_wb_arbiter against a queue-based model.
module tb_fp_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_we, pipe_we, dv_valid;
  logic [4:0]    ld_wn, pipe_wn, dv_wn;
  logic [31:0]   ld_d, pipe_d, dv_d;
  logic          dv_ready, wex, wey;
  logic [4:0]    wnx, wny;
  logic [31:0]   dx, dy, pend_mask;
  logic [AW:0]   q_count;

  fp_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_we(ld_we), .ld_wn(ld_wn), .ld_d(ld_d),
    .pipe_we(pipe_we), .pipe_wn(pipe_wn), .pipe_d(pipe_d),
    .dv_valid(dv_valid), .dv_ready(dv_ready), .dv_wn(dv_wn), .dv_d(dv_d),
    .wex(wex), .wnx(wnx), .dx(dx), .wey(wey), .wny(wny), .dy(dy),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          ncmp = 0;
  int          nfail = 0;
  bit          e_xw, e_yw;
  logic [4:0]  e_xwn, e_ywn;
  logic [31:0] e_xd, e_yd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; ld_we = 1'b0; pipe_we = 1'b0; dv_valid = 1'b0;
  endtask

  function automatic bit killed(input logic [4:0] wn);
    return (ld_we && ld_wn == wn) || (pipe_we && pipe_wn == wn);
  endfunction

  // One clock: check registered-state outputs, advance the model, step, check ports.
  task automatic cycle();
    bit          rdy;
    logic [31:0] pm;
    rdy = (mq.size() < DEPTH);
    pm  = '0;
    foreach (mq[i]) if (mq[i].live) pm[mq[i].wn] = 1'b1;
    chk("dv_ready", 64'(dv_ready), 64'(rdy));
    chk("pend_mask", 64'(pend_mask), 64'(pm));
    chk("q_count", 64'(q_count), 64'(mq.size()));

    if (!rst_n) begin
      mq.delete();
      e_xw = 0; e_yw = 0;
    end else begin
      foreach (mq[i]) if (killed(mq[i].wn)) mq[i].live = 0;
      e_xw = ld_we;   e_xwn = ld_wn;   e_xd = ld_d;
      e_yw = pipe_we; e_ywn = pipe_wn; e_yd = pipe_d;
      if (mq.size() > 0) begin
        if (!mq[0].live) begin
          void'(mq.pop_front());
        end else if (!ld_we) begin
          e_xw = 1; e_xwn = mq[0].wn; e_xd = mq[0].d;
          void'(mq.pop_front());
        end else if (!pipe_we) begin
          e_yw = 1; e_ywn = mq[0].wn; e_yd = mq[0].d;
          void'(mq.pop_front());
        end
      end
      if (dv_valid && rdy) mq.push_back('{wn: dv_wn, d: dv_d, live: !killed(dv_wn)});
    end

    @(posedge clk); #1;
    if (e_xw) chk("port_x", {26'(wex), wnx, dx}, {26'd1, e_xwn, e_xd});
    else      chk("wex_idle", 64'(wex), 64'd0);
    if (e_yw) chk("port_y", {26'(wey), wny, dy}, {26'd1, e_ywn, e_yd});
    else      chk("wey_idle", 64'(wey), 64'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    ld_wn = '0; pipe_wn = '0; dv_wn = '0; ld_d = '0; pipe_d = '0; dv_d = '0;
    @(posedge clk); #1;

    // Reset held two cycles with traffic present.
    ld_we = 1; ld_wn = 4; ld_d = 32'h1; pipe_we = 1; pipe_wn = 6; pipe_d = 32'h2;
    dv_valid = 1; dv_wn = 9; dv_d = 32'h3;
    rst_n = 0;
    cycle();
    cycle();
    idle();
    chk("rst_wex", 64'(wex), 0);
    chk("rst_wey", 64'(wey), 0);
    chk("rst_pend", 64'(pend_mask), 0);
    chk("rst_qcnt", 64'(q_count), 0);
    chk("rst_ready", 64'(dv_ready), 1);

    // Single load write.
    ld_we = 1; ld_wn = 3; ld_d = 32'h3F800000;
    cycle();
    idle();
    chk("ld_wnx", 64'(wnx), 3);
    chk("ld_dx", 64'(dx), 64'h3F800000);

    // Divide result through the queue: 2-cycle latency.
    dv_valid = 1; dv_wn = 5; dv_d = 32'h40490FDB;
    cycle();
    idle();
    chk("dv_pend5", 64'(pend_mask[5]), 1);
    chk("dv_nobypass", 64'(wex), 0);
    cycle();
    chk("dv_wnx", 64'(wnx), 5);
    chk("dv_dx", 64'(dx), 64'h40490FDB);
    chk("dv_pend_clr", 64'(pend_mask), 0);
    chk("dv_qcnt0", 64'(q_count), 0);

    // Fill with both ports busy.
    ld_we = 1; ld_wn = 1; ld_d = 32'hA; pipe_we = 1; pipe_wn = 2; pipe_d = 32'hB;
    for (int i = 0; i < 4; i++) begin
      dv_valid = 1; dv_wn = 5'(8 + i); dv_d = 32'hD000 + 32'(i);
      cycle();
    end
    chk("full_qcnt", 64'(q_count), 4);
    chk("full_ready", 64'(dv_ready), 0);
    chk("full_pend", 64'(pend_mask), 64'h0F00);
    dv_wn = 12; dv_d = 32'hD004;
    cycle();
    chk("held_qcnt", 64'(q_count), 4);

    // Drain on port y in order while the fifth result waits.
    pipe_we = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i >= 1) dv_valid = 0;
      chk("drain_order", 64'(wny), 64'(8 + i));
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("drain_empty", 64'(q_count), 0);

    // Kill: queued r7 superseded by a pipeline write to r7.
    ld_we = 1; ld_wn = 1; pipe_we = 1; pipe_wn = 2;
    dv_valid = 1; dv_wn = 7; dv_d = 32'hDEADBEEF;
    cycle();
    dv_valid = 0; pipe_wn = 7; pipe_d = 32'h11111111;
    cycle();
    chk("kill_pend7", 64'(pend_mask[7]), 0);
    chk("kill_y7", {27'(wny), dy}, {27'd7, 32'h11111111});
    idle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("kill_nowrite", 64'({wex, wey}), 0);
    end

    // Reset with three entries queued.
    ld_we = 1; ld_wn = 1; pipe_we = 1; pipe_wn = 2;
    for (int i = 0; i < 3; i++) begin
      dv_valid = 1; dv_wn = 5'(20 + i); dv_d = 32'hE000 + 32'(i);
      cycle();
    end
    chk("mid_qcnt3", 64'(q_count), 3);
    idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("mid_ready", 64'(dv_ready), 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mid_nowrite", 64'({wex, wey}), 0);
    end

    // Randomized traffic with a narrow register range to provoke kills.
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      ld_we    = ($urandom_range(0, 99) < 55);
      pipe_we  = ($urandom_range(0, 99) < 55);
      dv_valid = ($urandom_range(0, 99) < 50);
      ld_wn    = 5'($urandom_range(0, 7));
      pipe_wn  = 5'($urandom_range(0, 7));
      dv_wn    = 5'($urandom_range(0, 7));
      ld_d     = $urandom;
      pipe_d   = $urandom;
      dv_d     = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
